// File: rtl/csa_tree_pipe_acc.sv
// csa_tree_pipe_acc
//   Pipelined Wallace-style 3:2 carry-save reduction of N operands, followed by
//   a registered carry-propagate add that feeds a first/last framed accumulator.
//   A single global stall (adv) freezes every register while a result is held
//   and downstream is not ready.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready = adv
//   in_data             N operands, operand k = in_data[k*W +: W]
//   in_signed           per-beat sign extension select (1 = two's complement)
//   in_first/in_last    accumulation frame delimiters
//   out_valid/out_ready downstream handshake
//   out_data            frame sum, OW = W + clog2(N) + ACC_BITS bits
//   out_ovf             sticky frame overflow, rule chosen by the last beat
module csa_tree_pipe_acc #(
    parameter int unsigned N         = 9,
    parameter int unsigned W         = 8,
    parameter int unsigned REG_EVERY = 2,
    parameter int unsigned ACC_BITS  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N*W-1:0]                    in_data,
    input  logic                              in_signed,
    input  logic                              in_first,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [W+$clog2(N)+ACC_BITS-1:0]   out_data,
    output logic                              out_ovf
);

    // Rows remaining after lvl levels of 3:2 compression.
    function automatic int unsigned rows_at(input int unsigned lvl);
        int unsigned r;
        r = N;
        for (int unsigned i = 0; i < lvl; i++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    function automatic int unsigned levels_for(input int unsigned n);
        int unsigned r;
        int unsigned l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            l++;
        end
        return l;
    endfunction

    localparam int unsigned LOGN   = $clog2(N);
    localparam int unsigned OW     = W + LOGN + ACC_BITS;
    localparam int unsigned LEVELS = levels_for(N);

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Operand extension to the full accumulator width.
    logic [OW-1:0] ext_rows [N];
    logic [3:0]    side0;   // {valid, signed, first, last}

    assign side0 = {in_valid, in_signed, in_first, in_last};

    for (genvar k = 0; k < N; k++) begin : g_ext
        logic [W-1:0] op;
        assign op          = in_data[k*W +: W];
        assign ext_rows[k] = {{(OW-W){in_signed & op[W-1]}}, op};
    end

    // One generate block per CSA level; each is registered at every
    // REG_EVERY-th level and at the last level, otherwise it is pure wiring.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned RI = rows_at(l);
        localparam int unsigned RO = rows_at(l + 1);
        localparam int unsigned NG = RI / 3;

        logic [OW-1:0] rows_in [RI];
        logic [OW-1:0] rows_d  [RO];
        logic [OW-1:0] rows_q  [RO];
        logic [3:0]    side_in;
        logic [3:0]    side_q;

        if (l == 0) begin : g_src
            assign rows_in = ext_rows;
            assign side_in = side0;
        end else begin : g_src
            assign rows_in = g_lvl[l-1].rows_q;
            assign side_in = g_lvl[l-1].side_q;
        end

        for (genvar g = 0; g < NG; g++) begin : g_csa
            logic [OW-1:0] a, b, c;
            assign a               = rows_in[3*g];
            assign b               = rows_in[3*g + 1];
            assign c               = rows_in[3*g + 2];
            assign rows_d[2*g]     = a ^ b ^ c;
            assign rows_d[2*g + 1] = ((a & b) | (a & c) | (b & c)) << 1;
        end

        // Rows left over from grouping by three bypass this level.
        for (genvar j = 0; j < RI % 3; j++) begin : g_pass
            assign rows_d[2*NG + j] = rows_in[3*NG + j];
        end

        if (((l + 1) % REG_EVERY == 0) || (l + 1 == LEVELS)) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    side_q <= '0;
                end else if (adv) begin
                    side_q <= side_in;
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    rows_q <= rows_d;
                end
            end
        end else begin : g_wire
            assign rows_q = rows_d;
            assign side_q = side_in;
        end
    end

    logic [OW-1:0] fin_a, fin_b;
    logic [3:0]    fin_side;

    if (LEVELS == 0) begin : g_fin
        assign fin_a    = ext_rows[0];
        assign fin_b    = ext_rows[1];
        assign fin_side = side0;
    end else begin : g_fin
        assign fin_a    = g_lvl[LEVELS-1].rows_q[0];
        assign fin_b    = g_lvl[LEVELS-1].rows_q[1];
        assign fin_side = g_lvl[LEVELS-1].side_q;
    end

    logic          fin_v, fin_s, fin_f, fin_l;
    logic [OW-1:0] tree_sum, acc, acc_sum, acc_nx;
    logic          carry, sovf;
    logic          ovf_u, ovf_s, ovf_u_nx, ovf_s_nx;

    assign {fin_v, fin_s, fin_f, fin_l} = fin_side;

    // Both overflow rules are tracked so the frame's last beat can pick one.
    always_comb begin
        tree_sum         = fin_a + fin_b;
        {carry, acc_sum} = {1'b0, acc} + {1'b0, tree_sum};
        sovf             = (acc[OW-1] == tree_sum[OW-1]) && (acc_sum[OW-1] != acc[OW-1]);
        acc_nx           = acc_sum;
        ovf_u_nx         = ovf_u | carry;
        ovf_s_nx         = ovf_s | sovf;
        if (fin_f) begin
            acc_nx   = tree_sum;
            ovf_u_nx = 1'b0;
            ovf_s_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ovf_u     <= 1'b0;
            ovf_s     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= fin_v & fin_l;
            if (fin_v) begin
                acc   <= acc_nx;
                ovf_u <= ovf_u_nx;
                ovf_s <= ovf_s_nx;
                if (fin_l) begin
                    out_data <= acc_nx;
                    out_ovf  <= fin_s ? ovf_s_nx : ovf_u_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_tree_pipe_acc.sv
// tb_csa_tree_pipe_acc
//   Two instances share one input stream: the default configuration (OW=20)
//   and a no-headroom configuration (ACC_BITS=0, OW=12). Expected frame sums
//   and overflow flags come from an integer-arithmetic model of the frame rules.
module tb_csa_tree_pipe_acc;

    localparam int unsigned N   = 9;
    localparam int unsigned W   = 8;
    localparam int unsigned OWA = 20;
    localparam int unsigned OWB = 12;
    localparam int unsigned LAT = 3;   // LEVELS(9)=4, ceil(4/2)+1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, in_signed, in_first, in_last, out_ready;
    logic [N*W-1:0] in_data;
    logic           in_ready_a, out_valid_a, out_ovf_a;
    logic [OWA-1:0] out_data_a;
    logic           in_ready_b, out_valid_b, out_ovf_b;
    logic [OWB-1:0] out_data_b;

    csa_tree_pipe_acc #(.N(N), .W(W), .REG_EVERY(2), .ACC_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_signed(in_signed), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a)
    );

    csa_tree_pipe_acc #(.N(N), .W(W), .REG_EVERY(2), .ACC_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_signed(in_signed), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b)
    );

    typedef struct {
        logic [OWA-1:0] da;
        logic           oa;
        logic [OWB-1:0] db;
        logic           ob;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           e_mon;
    longint         acc_m [2];
    bit             ovfu_m [2];
    bit             ovfs_m [2];
    int unsigned    n_checks = 0, n_errors = 0, n_out = 0;
    logic [OWA-1:0] last_da, held_da;
    logic [OWB-1:0] last_db;
    logic           last_oa, last_ob, held_oa;
    bit             held = 0;
    bit             bp_mode = 0;
    int unsigned    hold_lo = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input longint m);
        return (v >= m / 2) ? v - m : v;
    endfunction

    // Frame arithmetic on plain integers for both output widths.
    task automatic model_beat();
        longint      s, m, ta, ua, sa;
        logic [W-1:0] op;
        int unsigned ows [2];
        exp_t        e;
        ows[0] = OWA;
        ows[1] = OWB;
        s = 0;
        for (int k = 0; k < N; k++) begin
            op = in_data[k*W +: W];
            s += longint'(op) - ((in_signed && op[W-1]) ? (longint'(1) << W) : 0);
        end
        for (int i = 0; i < 2; i++) begin
            m  = longint'(1) << ows[i];
            ta = s & (m - 1);
            if (in_first) begin
                acc_m[i]  = ta;
                ovfu_m[i] = 0;
                ovfs_m[i] = 0;
            end else begin
                ua = acc_m[i] + ta;
                sa = sx(acc_m[i], m) + sx(ta, m);
                if (ua >= m) ovfu_m[i] = 1;
                if (sa >= m / 2 || sa < -(m / 2)) ovfs_m[i] = 1;
                acc_m[i] = ua % m;
            end
        end
        if (in_last) begin
            e.da = OWA'(acc_m[0]);
            e.db = OWB'(acc_m[1]);
            e.oa = in_signed ? ovfs_m[0] : ovfu_m[0];
            e.ob = in_signed ? ovfs_m[1] : ovfu_m[1];
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 2; i++) begin
                acc_m[i]  = 0;
                ovfu_m[i] = 0;
                ovfs_m[i] = 0;
            end
            held = 0;
        end else begin
            if (held) begin
                check("stall_valid", out_valid_a, 1'b1);
                check("stall_data", out_data_a, held_da);
                check("stall_ovf", out_ovf_a, held_oa);
            end
            held    = out_valid_a && !out_ready;
            held_da = out_data_a;
            held_oa = out_ovf_a;
            if (out_valid_a && !out_ready) check("in_ready_stall", in_ready_a, 1'b0);
            check("valid_pair", out_valid_b, out_valid_a);
            check("ready_pair", in_ready_b, in_ready_a);
            if (out_valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid_a, 1'b0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("data_a", out_data_a, e_mon.da);
                    check("ovf_a", out_ovf_a, e_mon.oa);
                    check("data_b", out_data_b, e_mon.db);
                    check("ovf_b", out_ovf_b, e_mon.ob);
                    last_da = out_data_a;
                    last_oa = out_ovf_a;
                    last_db = out_data_b;
                    last_ob = out_ovf_b;
                    n_out++;
                end
            end
            if (in_valid && in_ready_a) model_beat();
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            if (hold_lo > 0) begin
                out_ready = 1'b0;
                hold_lo--;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = v;
        return d;
    endfunction

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(k);
        return d;
    endfunction

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom_range(0, 255));
        return d;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [N*W-1:0] d, input logic sg, input logic fi, input logic la);
        bit          ok;
        int unsigned g;
        in_data   = d;
        in_signed = sg;
        in_first  = fi;
        in_last   = la;
        in_valid  = 1'b1;
        ok = 0;
        g  = 0;
        while (!ok && g < 500) begin
            @(negedge clk);
            ok = in_ready_a;
            tick();
            g++;
        end
        if (!ok) check("accept_timeout", in_ready_a, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int unsigned target, input string tag);
        int unsigned g;
        g = 0;
        while (n_out < target && g < 300) begin
            tick();
            g++;
        end
        check(tag, 64'(n_out >= target), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned base, nfr, len;
        bit          sg;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid_a, 1'b0);
        check("rst_data", out_data_a, 0);
        check("rst_ovf", out_ovf_a, 1'b0);
        check("rst_ready", in_ready_a, 1'b1);
        check("rst_data_b", out_data_b, 0);
        tick();

        // Latency: single unsigned beat of 255s.
        send(fill(8'hFF), 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c < LAT) begin
                check("lat_early", out_valid_a, 1'b0);
            end else begin
                check("lat_valid", out_valid_a, 1'b1);
                check("lat_data", out_data_a, 2295);
                check("lat_ovf", out_ovf_a, 1'b0);
            end
        end
        tick();

        // Signed single beat of -128s.
        base = n_out;
        send(fill(8'h80), 1'b1, 1'b1, 1'b1);
        wait_out(base + 1, "sgn_wait");
        check("sgn_data_a", last_da, 20'hFFB80);
        check("sgn_data_b", last_db, 12'hB80);
        check("sgn_ovf", last_oa, 1'b0);

        // Four-beat frame, each beat 0..8.
        base = n_out;
        for (int b = 0; b < 4; b++) send(ramp(), 1'b0, b == 0, b == 3);
        wait_out(base + 1, "frame4_wait");
        repeat (4) tick();
        check("frame4_count", n_out, base + 1);
        check("frame4_data", last_da, 144);

        // Overflow in the 12-bit instance, then cleared by a new frame.
        base = n_out;
        send(fill(8'hFF), 1'b0, 1'b1, 1'b0);
        send(fill(8'hFF), 1'b0, 1'b0, 1'b1);
        wait_out(base + 1, "ovf_wait");
        check("ovf_data_b", last_db, 494);
        check("ovf_flag_b", last_ob, 1'b1);
        check("ovf_data_a", last_da, 4590);
        check("ovf_flag_a", last_oa, 1'b0);
        send(fill(8'hFF), 1'b0, 1'b1, 1'b1);
        wait_out(base + 2, "ovf_clr_wait");
        check("ovf_clr_flag", last_ob, 1'b0);
        check("ovf_clr_data", last_db, 2295);

        // Reset in the middle of a frame.
        base = n_out;
        send(ramp(), 1'b0, 1'b1, 1'b0);
        send(ramp(), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(fill(8'h01), 1'b0, 1'b1, 1'b1);
        wait_out(base + 1, "rst_frame_wait");
        repeat (5) tick();
        check("rst_frame_count", n_out, base + 1);
        check("rst_frame_data", last_da, 9);

        // Backpressure: single-beat frames, then random multi-beat frames.
        base    = n_out;
        hold_lo = 5;
        bp_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send(rnd_data(), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        nfr     = 12;
        hold_lo = 5;
        for (int f = 0; f < int'(nfr); f++) begin
            len = $urandom_range(1, 4);
            sg  = 1'($urandom_range(0, 1));
            for (int b = 0; b < int'(len); b++) begin
                send(($urandom_range(0, 3) == 0) ? fill(sg ? 8'h7F : 8'hFF) : rnd_data(),
                     sg, b == 0, b == int'(len) - 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        bp_mode = 0;
        wait_out(base + 10 + nfr, "bp_drain");
        repeat (5) tick();
        check("bp_count", n_out, base + 10 + nfr);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
